// File: rtl/mux_2_if.sv
// Word-select bundle for mux_2: two data words, a select,
// and the combinational and registered results.
interface mux_2_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;

  modport master (
    output d0,
    output d1,
    output sel,
    input  y,
    input  y_q
  );

  modport slave (
    input  d0,
    input  d1,
    input  sel,
    output y,
    output y_q
  );
endinterface

// File: rtl/mux_2.sv
// 2:1 word mux with a same-cycle output and a registered copy.
// Reset only clears the registered copy.
module mux_2 #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset,
  mux_2_if.slave  bus
);
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;

  // Plain ?: keeps standard X-merge behaviour on an unknown select
  assign w_y   = bus.sel ? bus.d1 : bus.d0;
  assign bus.y = w_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y_q <= '0;
    end else begin
      r_y_q <= w_y;
    end
  end

  assign bus.y_q = r_y_q;
endmodule

// File: tb/tb_mux_2.sv
// Bench for mux_2: direct checks on y, queued
// expectations for the registered y_q.
module tb_mux_2;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  logic [W-1:0] exp_q[$];

  mux_2_if #(.WIDTH(W)) bus ();

  mux_2 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [W-1:0] got,
    input logic [W-1:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(
    input logic         s,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = s ? b[i] : a[i];
    return r;
  endfunction

  task automatic drive(
    input logic         s,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    bus.sel = s;
    bus.d0  = a;
    bus.d1  = b;
    #1;
  endtask

  task automatic comb(input string tag);
    check(tag, bus.y, model(bus.sel, bus.d0, bus.d1));
  endtask

  // Push what y_q must hold after this edge, then pop and compare
  task automatic tick(input string tag);
    logic [W-1:0] e;
    exp_q.push_back(reset ? '0 : model(bus.sel, bus.d0, bus.d1));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, bus.y_q, e);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    drive(1'b0, '0, '0);
    @(negedge clk);
    tick("rst_q");
    check("rst_y", bus.y, 32'h0);

    drive(1'b0, 32'h419c03fc, 32'h6b58400b);
    check("sel0", bus.y, 32'h419c03fc);
    drive(1'b1, 32'h419c03fc, 32'h6b58400b);
    check("sel1", bus.y, 32'h6b58400b);
    drive(1'b1, 32'h12345678, 32'h6b58400b);
    check("unsel_d0", bus.y, 32'h6b58400b);

    drive(1'b1, 32'h74d7edc6, 32'hb6f0d434);
    check("data1", bus.y, 32'hb6f0d434);
    drive(1'b0, 32'h74d7edc6, 32'hb6f0d434);
    check("data0", bus.y, 32'h74d7edc6);
    drive(1'b0, 32'h74d7edc6, 32'h0badf00d);
    check("unsel_d1", bus.y, 32'h74d7edc6);

    drive(1'b0, 32'hdc2242bd, 32'hba5fb2db);
    check("v3_sel0", bus.y, 32'hdc2242bd);
    drive(1'b1, 32'hdc2242bd, 32'hba5fb2db);
    check("v3_sel1", bus.y, 32'hba5fb2db);

    reset = 1'b1;
    drive(1'b0, 32'h419c03fc, 32'h6b58400b);
    tick("rst_hold_q");
    check("rst_hold_q0", bus.y_q, 32'h0);
    check("rst_hold_y", bus.y, 32'h419c03fc);

    reset = 1'b0;
    drive(1'b1, 32'h419c03fc, 32'h6b58400b);
    tick("rel_q");
    check("rel_q_lit", bus.y_q, 32'h6b58400b);
    drive(1'b0, 32'h419c03fc, 32'h6b58400b);
    check("q_lag", bus.y_q, 32'h6b58400b);
    tick("follow_d0");
    check("follow_lit", bus.y_q, 32'h419c03fc);

    drive(1'b1, 32'hdc2242bd, 32'hba5fb2db);
    tick("mid_pre");
    check("mid_pre_lit", bus.y_q, 32'hba5fb2db);
    reset = 1'b1;
    #1;
    check("rst_async", bus.y_q, 32'hba5fb2db);
    check("rst_mid_y", bus.y, 32'hba5fb2db);
    tick("mid_rst");
    check("mid_rst_lit", bus.y_q, 32'h0);
    reset = 1'b0;
    tick("mid_reload");
    check("mid_reload_lit", bus.y_q, 32'hba5fb2db);

    drive(1'b0, 32'h11111111, 32'h22222222);
    drive(1'b1, 32'h33333333, 32'h44444444);
    drive(1'b0, 32'h55555555, 32'h66666666);
    tick("settle");
    check("settle_lit", bus.y_q, 32'h55555555);

    drive(1'b1, 32'h0, 32'hffffffff);
    comb("ones");
    tick("ones_q");

    for (int i = 0; i < 24; i++) begin
      reset = ($urandom_range(0, 7) == 0);
      drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
      comb("rnd_y");
      tick("rnd_q");
    end

    reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mux_2.md
# mux_2

Parameterised 2:1 word multiplexer used throughout the RISC-V pipeline datapath for operand, PC-source and write-back selection. It drives a purely combinational selected word for same-cycle use. It also provides a registered copy of that word for stages that need a pipelined version. One clock, synchronous active-high reset; reset affects only the registered output.

## Interface
- WIDTH, 32, data word width in bits; legal range 1..64.
- clk  input  1  rising-edge clock; used only by the registered output.
- reset  input  1  synchronous, active-high reset; clears the registered output.
- d0  input  WIDTH  data selected when sel = 0.
- d1  input  WIDTH  data selected when sel = 1.
- sel  input  1  select: 0 picks d0, 1 picks d1.
- y  output  WIDTH  combinational selected word.
- y_q  output  WIDTH  registered selected word, one clk behind y.

## Operation
- y = sel ? d1 : d0, continuously, for every bit.
- No clock dependency on y: any change on d0, d1 or sel propagates to y in the same delta/time step.
- y is independent of reset; y is valid during and after reset.
- Only the input named by sel affects y; changes on the unselected input leave y unchanged.
- y_q captures y on every rising clk edge when reset = 0; no enable, so it updates every cycle.
- Unknown sel (X/Z) in simulation:
  - Bits where d0 and d1 agree output that value.
  - Other bits output X.
  - Standard conditional-operator semantics apply; no extra logic is added for this.
- No internal state other than the y_q register; no FSM.
- Width rule: d0, d1, y and y_q are all exactly WIDTH bits; no extension or truncation.

## Timing
- y: zero-cycle latency; purely combinational path from d0, d1 and sel to y.
- y_q: one-cycle latency. y_q after edge N equals y sampled just before edge N.
- Reset:
  - reset = 1 at a rising edge makes y_q = 0 after that edge.
  - Asynchronous reset assertion has no effect until the next edge.
- Reset mid-operation: y_q is forced to 0 at the next edge; y is unaffected.
- First edge after reset deasserts loads the current y.
- Simultaneous change of sel and data between edges: y_q captures only the final settled y before the edge.

## Test plan
- Select d0: d0=0x419c03fc, d1=0x6b58400b, sel=0 -> y=0x419c03fc within the same time step.
- Switch select: same data, sel=1 -> y=0x6b58400b; changing d0 while sel=1 leaves y unchanged.
- Data change while selected: sel=1, d0=0x74d7edc6, d1=0xb6f0d434 -> y=0xb6f0d434; then sel=0 -> y=0x74d7edc6.
- Third vector pair: d0=0xdc2242bd, d1=0xba5fb2db:
  - sel=0 -> y=0xdc2242bd.
  - sel=1 -> y=0xba5fb2db.
- Registered path:
  - Hold reset=1 across one edge -> y_q=0x00000000 while y still tracks the inputs.
  - Release reset with sel=1, d1=0x6b58400b -> y_q=0x6b58400b after the next edge.
  - Set sel=0 -> y_q follows to d0 one edge later.
- Reset mid-stream: y_q=0xba5fb2db, assert reset for one edge -> y_q=0. Deassert -> y_q reloads the current y on the following edge.
